// File: rtl/k_16_pkg.sv
// Shared constants and types for the k-means centroid divide sequencer.
// FP16 field layout, the quiet-NaN result and the sequencer FSM encoding.
package k_16_pkg;

  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam int          FP16_SIGN_BIT = 15;
  localparam int          FP16_EXP_MSB  = 14;
  localparam int          FP16_EXP_LSB  = 10;
  localparam int          FP16_MANT_MSB = 9;
  localparam int          FP16_MANT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_CHK,
    ST_DIV,
    ST_WR,
    ST_NXT,
    ST_FIN
  } state_e;

  // Magnitude zero test: sign bit ignored so +0 and -0 both match.
  function automatic logic fp16_is_zero(input logic [15:0] v);
    return (v[FP16_EXP_MSB:FP16_EXP_LSB] == '0) && (v[FP16_MANT_MSB:FP16_MANT_LSB] == '0);
  endfunction

endpackage

// File: rtl/k_16_centroid_div_seq_if.sv
// Bundle between the centroid sequencer and its surroundings: control, accumulator
// read port, centroid write port and divider request/response.
interface k_16_centroid_div_seq_if #(
  parameter int AW = 3
);
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] acc_addr;
  logic [15:0]   acc_sum;
  logic [15:0]   acc_cnt;
  logic          cent_we;
  logic [AW-1:0] cent_addr;
  logic [15:0]   cent_data;
  logic [15:0]   div_in1;
  logic [15:0]   div_in2;
  logic          div_en;
  logic [15:0]   div_out;
  logic          div_done;

  modport master (
    input  start, acc_sum, acc_cnt, div_out, div_done,
    output busy, done, err, acc_addr, cent_we, cent_addr, cent_data, div_in1, div_in2, div_en
  );

  modport slave (
    output start, acc_sum, acc_cnt, div_out, div_done,
    input  busy, done, err, acc_addr, cent_we, cent_addr, cent_data, div_in1, div_in2, div_en
  );
endinterface

// File: rtl/k_16_centroid_div_seq.sv
// Walks every (cluster, dim) element, divides sum by count via the external divider and writes
// the centroid; empty clusters are skipped, zero sums bypass the divider, stalls abort to qNaN.
module k_16_centroid_div_seq
  import k_16_pkg::*;
#(
  parameter int NUM_CLUSTERS = 4,
  parameter int NUM_DIMS     = 2,
  parameter int AW           = 3,
  parameter int DIV_TIMEOUT  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  k_16_centroid_div_seq_if.master   bus
);

  localparam int            NUM_ELEMS = NUM_CLUSTERS * NUM_DIMS;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_ELEMS - 1);
  localparam int            TW        = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DIV_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   sum_q, sum_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   res_q, res_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RD;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      ST_RD:  state_d = ST_RDW;
      ST_RDW: begin
        sum_d   = bus.acc_sum;
        cnt_d   = bus.acc_cnt;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        tmo_d = '0;
        if (fp16_is_zero(cnt_q)) begin
          state_d = ST_NXT;
        end else if (fp16_is_zero(sum_q)) begin
          res_d   = {sum_q[FP16_SIGN_BIT] ^ cnt_q[FP16_SIGN_BIT], 15'h0};
          state_d = ST_WR;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (bus.div_done) begin
          res_d   = bus.div_out;
          state_d = ST_WR;
        end else if (tmo_q == TMO_LAST) begin
          // Divider never answered: poison the centroid and flag the pass.
          res_d   = FP16_QNAN;
          err_d   = 1'b1;
          state_d = ST_WR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WR:  state_d = ST_NXT;
      ST_NXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_RD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.acc_addr  = '0;
    bus.cent_we   = 1'b0;
    bus.cent_addr = '0;
    bus.cent_data = '0;
    bus.div_en    = 1'b0;
    bus.div_in1   = '0;
    bus.div_in2   = '0;
    case (state_q)
      ST_RD: begin
        bus.busy     = 1'b1;
        bus.acc_addr = idx_q;
      end
      ST_RDW, ST_CHK, ST_NXT: bus.busy = 1'b1;
      ST_DIV: begin
        bus.busy    = 1'b1;
        bus.div_en  = 1'b1;
        bus.div_in1 = sum_q;
        bus.div_in2 = cnt_q;
      end
      ST_WR: begin
        bus.busy      = 1'b1;
        bus.cent_we   = 1'b1;
        bus.cent_addr = idx_q;
        bus.cent_data = res_q;
      end
      ST_FIN:  bus.done = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_k_16_centroid_div_seq.sv
// Directed bench for the centroid divide sequencer with accumulator RAM and divider stub models.
// An element-level model predicts writes, pass length, divider requests and error flag per pass.
module tb_k_16_centroid_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  k_16_centroid_div_seq_if #(.AW(3)) bus();

  k_16_centroid_div_seq #(
    .NUM_CLUSTERS(4),
    .NUM_DIMS(2),
    .AW(3),
    .DIV_TIMEOUT(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accumulator RAM with one-cycle registered read, and a divider stub.
  logic [15:0] sum_mem [8];
  logic [15:0] cnt_mem [8];
  logic [2:0]  rd_addr_q;
  logic [15:0] stub_out;
  logic [15:0] stub_block;
  int          stub_dly;
  logic        glitch;
  int          en_cnt = 0;

  always @(posedge clk) begin
    rd_addr_q <= bus.acc_addr;
    en_cnt    <= bus.div_en ? en_cnt + 1 : 0;
  end

  assign bus.acc_sum  = sum_mem[rd_addr_q];
  assign bus.acc_cnt  = cnt_mem[rd_addr_q];
  assign bus.div_out  = stub_out;
  assign bus.div_done = (bus.div_en && en_cnt == stub_dly && bus.div_in1 != stub_block)
                        || (glitch && !bus.div_en);

  // Monitor: every write against the expected queue, divider operand stability, request count.
  logic [18:0] exp_q [$];
  logic [18:0] exp_e;
  logic [15:0] obs_data [8];
  int          wr_cnt = 0;
  int          div_rises = 0;
  int          done_cnt = 0;
  logic        prev_en = 1'b0;
  logic [15:0] prev_in1, prev_in2;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (bus.cent_we) begin
        wr_cnt++;
        obs_data[bus.cent_addr] = bus.cent_data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                   bus.cent_addr, bus.cent_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 32'(bus.cent_addr), 32'(exp_e[18:16]));
          check("wr_data", 32'(bus.cent_data), 32'(exp_e[15:0]));
        end
      end
      if (bus.div_en) begin
        if (prev_en) begin
          check("div_in1_stable", 32'(bus.div_in1), 32'(prev_in1));
          check("div_in2_stable", 32'(bus.div_in2), 32'(prev_in2));
        end else begin
          div_rises++;
        end
      end
      prev_en  = bus.div_en;
      prev_in1 = bus.div_in1;
      prev_in2 = bus.div_in2;
      if (bus.done) done_cnt++;
    end
  end

  // Element-level model: per element decide skip / signed zero / quotient / qNaN and its cycle cost.
  task automatic build_model(output int len, output logic err_e, output int ndiv);
    len   = 1;
    err_e = 1'b0;
    ndiv  = 0;
    exp_q.delete();
    for (int e = 0; e < 8; e++) begin
      if (cnt_mem[e][14:0] == 15'd0) begin
        len += 4;
      end else if (sum_mem[e][14:0] == 15'd0) begin
        exp_q.push_back({3'(e), sum_mem[e][15] ^ cnt_mem[e][15], 15'h0});
        len += 5;
      end else begin
        ndiv++;
        if (sum_mem[e] == stub_block) begin
          exp_q.push_back({3'(e), 16'h7E00});
          err_e = 1'b1;
          len += 3 + 8 + 2;
        end else begin
          exp_q.push_back({3'(e), stub_out});
          len += 3 + (stub_dly + 1) + 2;
        end
      end
    end
  endtask

  int last_len;

  task automatic run_pass(input string tag, input bit stray);
    int   len_e;
    logic err_e;
    int   ndiv_e;
    int   n;
    build_model(len_e, err_e, ndiv_e);
    div_rises = 0;
    done_cnt  = 0;
    wr_cnt    = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n = 1;
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_err_cleared"}, 32'(bus.err), 32'd0);
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
      bus.start = (stray && (n == 20 || n == 40)) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check({tag, "_len"}, 32'(n), 32'(len_e));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_err_at_done"}, 32'(bus.err), 32'(err_e));
    repeat (5) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_div_reqs"}, 32'(div_rises), 32'(ndiv_e));
    check({tag, "_err_sticky"}, 32'(bus.err), 32'(err_e));
    last_len = n;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 8; i++) begin
      sum_mem[i] = 16'h4600;
      cnt_mem[i] = 16'h4000;
    end
    stub_out   = 16'h4200;
    stub_block = 16'hFFFF;
    stub_dly   = 1;
    glitch     = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    set_defaults();
    for (int i = 0; i < 8; i++) obs_data[i] = 16'h0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_we", 32'(bus.cent_we), 32'd0);
    check("rst_div_en", 32'(bus.div_en), 32'd0);
    check("rst_acc_addr", 32'(bus.acc_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal pass: every element divides in two cycles.
    run_pass("t1", 1'b0);
    check("t1_len_lit", 32'(last_len), 32'd57);
    check("t1_writes_lit", 32'(wr_cnt), 32'd8);
    check("t1_data0_lit", 32'(obs_data[0]), 32'h4200);
    check("t1_data7_lit", 32'(obs_data[7]), 32'h4200);

    // Slower divider: four DIV cycles per element.
    stub_dly = 3;
    stub_out = 16'h4248;
    run_pass("t1b", 1'b0);
    check("t1b_len_lit", 32'(last_len), 32'd73);
    check("t1b_data3_lit", 32'(obs_data[3]), 32'h4248);

    // Empty cluster 1, plus stray div_done while the divider is idle.
    set_defaults();
    stub_out   = 16'h3E00;
    cnt_mem[2] = 16'h0000;
    cnt_mem[3] = 16'h0000;
    glitch     = 1'b1;
    run_pass("t2", 1'b0);
    check("t2_writes_lit", 32'(wr_cnt), 32'd6);
    check("t2_len_lit", 32'(last_len), 32'd51);
    check("t2_addr2_kept", 32'(obs_data[2]), 32'h4248);

    // Negative zero sum bypasses the divider.
    set_defaults();
    stub_out   = 16'h4400;
    sum_mem[0] = 16'h8000;
    cnt_mem[0] = 16'h3C00;
    run_pass("t3", 1'b0);
    check("t3_negzero_lit", 32'(obs_data[0]), 32'h8000);
    check("t3_div_reqs_lit", 32'(div_rises), 32'd7);
    check("t3_len_lit", 32'(last_len), 32'd55);

    // Divider stalls on addr 5: timeout, qNaN, sticky err; next pass clears it.
    set_defaults();
    sum_mem[5] = 16'h4700;
    stub_block = 16'h4700;
    run_pass("t4", 1'b0);
    check("t4_len_lit", 32'(last_len), 32'd63);
    check("t4_qnan_lit", 32'(obs_data[5]), 32'h7E00);
    check("t4_err_lit", 32'(bus.err), 32'd1);
    set_defaults();
    run_pass("t4b", 1'b0);
    check("t4b_err_lit", 32'(bus.err), 32'd0);

    // Reset during the divide of addr 3.
    set_defaults();
    begin
      int   len_e;
      logic err_e;
      int   ndiv_e;
      build_model(len_e, err_e, ndiv_e);
    end
    wr_cnt = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n = 0;
    while (!(bus.div_en && wr_cnt == 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_div3", 32'(bus.div_en && wr_cnt == 3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_div_en", 32'(bus.div_en), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_we", 32'(bus.cent_we), 32'd0);
    check("t5_div_in1", 32'(bus.div_in1), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_no_partial_write", 32'(wr_cnt), 32'd3);
    run_pass("t5r", 1'b0);
    check("t5r_writes_lit", 32'(wr_cnt), 32'd8);

    // Start pulses while busy are ignored.
    stub_out = 16'h4500;
    run_pass("t6", 1'b1);
    check("t6_len_lit", 32'(last_len), 32'd57);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
